// File: rtl/int_mult_pipe_pkg.sv
// Shared definitions for the pipelined integer multiplier: result-select
// encodings, slice-count derivation and carry-save tree sizing helpers.
package int_mult_pipe_pkg;

  // Result-select encodings carried with each operation (2'b11 acts as full)
  localparam logic [1:0] MODE_FULL = 2'b00;
  localparam logic [1:0] MODE_LO   = 2'b01;
  localparam logic [1:0] MODE_HI   = 2'b10;

  // Number of CHUNK_W slices needed to cover a DATA_W operand
  function automatic int unsigned calc_nch(input int unsigned data_w,
                                           input int unsigned chunk_w);
    return (data_w + chunk_w - 1) / chunk_w;
  endfunction

  // Vector count after one layer of 3:2 compressors (leftovers pass through)
  function automatic int unsigned csa_next_count(input int unsigned n);
    return 2 * (n / 3) + (n % 3);
  endfunction

  // Vector count present at the input of a given tree level
  function automatic int unsigned csa_count_at(input int unsigned n,
                                               input int unsigned level);
    int unsigned c;
    c = n;
    for (int unsigned k = 0; k < level; k++) begin
      c = csa_next_count(c);
    end
    return c;
  endfunction

  // Number of 3:2 layers needed to reduce n vectors down to two
  function automatic int unsigned csa_levels(input int unsigned n);
    int unsigned c;
    int unsigned l;
    c = n;
    l = 0;
    while (c > 2) begin
      c = csa_next_count(c);
      l++;
    end
    return l;
  endfunction

endpackage

// File: rtl/int_mult_pipe_csa_tree.sv
// Purely combinational Wallace-style carry-save tree: reduces N_IN vectors of
// width W to a carry/sum pair whose modular sum equals the modular input sum.
module int_mult_pipe_csa_tree
  import int_mult_pipe_pkg::*;
#(
  parameter int unsigned N_IN = 4,
  parameter int unsigned W    = 32
) (
  input  logic [N_IN*W-1:0] in_vec,
  output logic [W-1:0]      carry_c,
  output logic [W-1:0]      sum_c
);

  localparam int unsigned LEVELS = csa_levels(N_IN);

  genvar l, j;

  // One vector array per level; level 0 is the unpacked input
  for (l = 0; l <= LEVELS; l++) begin : g_lvl
    logic [W-1:0] v [N_IN];

    if (l == 0) begin : g_src
      for (j = 0; j < N_IN; j++) begin : g_in
        assign v[j] = in_vec[j*W +: W];
      end
    end else begin : g_red
      localparam int unsigned CNT = csa_count_at(N_IN, l - 1);
      localparam int unsigned GRP = CNT / 3;
      localparam int unsigned NXT = csa_next_count(CNT);

      for (j = 0; j < N_IN; j++) begin : g_slot
        if (j < 2 * GRP) begin : g_cmp
          localparam int unsigned B = 3 * (j / 2);
          if (j % 2 == 0) begin : g_sum
            assign v[j] = g_lvl[l-1].v[B] ^ g_lvl[l-1].v[B+1] ^ g_lvl[l-1].v[B+2];
          end else begin : g_cry
            // Majority shifted up one bit; the bit shifted past W is beyond
            // the product range and is intentionally dropped
            assign v[j] = ((g_lvl[l-1].v[B]   & g_lvl[l-1].v[B+1]) |
                           (g_lvl[l-1].v[B]   & g_lvl[l-1].v[B+2]) |
                           (g_lvl[l-1].v[B+1] & g_lvl[l-1].v[B+2])) << 1;
          end
        end else if (j < NXT) begin : g_pass
          assign v[j] = g_lvl[l-1].v[3*GRP + j - 2*GRP];
        end else begin : g_zero
          assign v[j] = '0;
        end
      end
    end
  end

  // Final pair; a single input degenerates to pass-through with zero carry
  if (N_IN == 1) begin : g_one
    assign sum_c   = g_lvl[0].v[0];
    assign carry_c = '0;
  end else begin : g_two
    assign sum_c   = g_lvl[LEVELS].v[0];
    assign carry_c = g_lvl[LEVELS].v[1];
  end

endmodule

// File: rtl/int_mult_pipe.sv
// Three-stage pipelined unsigned multiplier with valid/ready on both sides,
// tag passthrough and full/low/high result select.
//   S1: shifted slice partial products
//   S2: carry/sum pair from the carry-save tree
//   S3: carry-propagate add plus result select (drives out_c)
module int_mult_pipe
  import int_mult_pipe_pkg::*;
#(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned CHUNK_W = 16,
  parameter int unsigned TAG_W   = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_a,
  input  logic [DATA_W-1:0]   in_b,
  input  logic [1:0]          in_mode,
  input  logic [TAG_W-1:0]    in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*DATA_W-1:0] out_c,
  output logic [TAG_W-1:0]    out_tag
);

  localparam int unsigned NCH    = calc_nch(DATA_W, CHUNK_W);
  localparam int unsigned NPP    = NCH * NCH;
  localparam int unsigned PW     = 2 * DATA_W;
  localparam int unsigned PAD_W  = NCH * CHUNK_W;
  localparam int unsigned PROD_W = 2 * CHUNK_W;

  // Operands zero-padded to a whole number of slices
  logic [PAD_W-1:0]   a_pad;
  logic [PAD_W-1:0]   b_pad;
  logic [NPP*PW-1:0]  pp_c;

  // Stage registers
  logic               s1_valid;
  logic [NPP*PW-1:0]  s1_pp;
  logic [1:0]         s1_mode;
  logic [TAG_W-1:0]   s1_tag;

  logic               s2_valid;
  logic [PW-1:0]      s2_carry;
  logic [PW-1:0]      s2_sum;
  logic [1:0]         s2_mode;
  logic [TAG_W-1:0]   s2_tag;

  // Combinational datapath
  logic [PW-1:0]      csa_carry_c;
  logic [PW-1:0]      csa_sum_c;
  logic [PW-1:0]      prod_c;
  logic [PW-1:0]      res_c;

  // Stage load enables: a stage loads when empty or when its content moves on
  logic               ld1_c;
  logic               ld2_c;
  logic               ld3_c;

  assign a_pad = PAD_W'(in_a);
  assign b_pad = PAD_W'(in_b);

  // Slice products placed at their weight; terms entirely above the product
  // range contribute nothing and are tied off
  genvar i, j;
  for (i = 0; i < NCH; i++) begin : g_pa
    for (j = 0; j < NCH; j++) begin : g_pb
      localparam int unsigned SH = (i + j) * CHUNK_W;
      localparam int unsigned K  = i * NCH + j;
      if (SH < PW) begin : g_pp
        logic [PROD_W-1:0] prod;
        assign prod = PROD_W'(a_pad[i*CHUNK_W +: CHUNK_W]) *
                      PROD_W'(b_pad[j*CHUNK_W +: CHUNK_W]);
        assign pp_c[K*PW +: PW] = PW'(prod) << SH;
      end else begin : g_nopp
        assign pp_c[K*PW +: PW] = '0;
      end
    end
  end

  // Backpressure chain from out_ready back to in_ready
  assign ld3_c    = !out_valid || out_ready;
  assign ld2_c    = !s2_valid  || ld3_c;
  assign ld1_c    = !s1_valid  || ld2_c;
  assign in_ready = ld1_c;

  // S1: capture partial products, mode and tag of an accepted operation
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_pp    <= '0;
      s1_mode  <= MODE_FULL;
      s1_tag   <= '0;
    end else if (ld1_c) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_pp   <= pp_c;
        s1_mode <= in_mode;
        s1_tag  <= in_tag;
      end
    end
  end

  int_mult_pipe_csa_tree #(
    .N_IN (NPP),
    .W    (PW)
  ) u_csa_tree (
    .in_vec  (s1_pp),
    .carry_c (csa_carry_c),
    .sum_c   (csa_sum_c)
  );

  // S2: capture reduced carry/sum pair
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_carry <= '0;
      s2_sum   <= '0;
      s2_mode  <= MODE_FULL;
      s2_tag   <= '0;
    end else if (ld2_c) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_carry <= csa_carry_c;
        s2_sum   <= csa_sum_c;
        s2_mode  <= s1_mode;
        s2_tag   <= s1_tag;
      end
    end
  end

  // Final carry-propagate add; carry out of PW bits is always zero
  assign prod_c = s2_carry + s2_sum;

  // Result select: low/high halves are zero-extended into the low bits
  always_comb begin
    res_c = prod_c;
    case (s2_mode)
      MODE_LO: res_c = PW'(prod_c[DATA_W-1:0]);
      MODE_HI: res_c = PW'(prod_c[PW-1:DATA_W]);
      default: res_c = prod_c;
    endcase
  end

  // S3: output register, held while the consumer stalls
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_c     <= '0;
      out_tag   <= '0;
    end else if (ld3_c) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        out_c   <= res_c;
        out_tag <= s2_tag;
      end
    end
  end

endmodule

// File: tb/tb_int_mult_pipe.sv
// Self-checking bench for int_mult_pipe: directed vectors on a 64-bit instance
// with a queue-based reference model, plus 40-bit and 16-bit instances for
// partial-slice and single-slice configurations.
module tb_int_mult_pipe;
  import int_mult_pipe_pkg::*;

  localparam int unsigned DW = 64;
  localparam int unsigned PW = 128;
  localparam int unsigned TW = 8;

  logic          clk;
  logic          reset;

  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_a;
  logic [DW-1:0] in_b;
  logic [1:0]    in_mode;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] out_c;
  logic [TW-1:0] out_tag;

  logic          w40_in_valid;
  logic          w40_in_ready;
  logic [39:0]   w40_a;
  logic [39:0]   w40_b;
  logic [1:0]    w40_mode;
  logic [7:0]    w40_tag;
  logic          w40_out_valid;
  logic          w40_out_ready;
  logic [79:0]   w40_out_c;
  logic [7:0]    w40_out_tag;

  logic          w16_in_valid;
  logic          w16_in_ready;
  logic [15:0]   w16_a;
  logic [15:0]   w16_b;
  logic [1:0]    w16_mode;
  logic [7:0]    w16_tag;
  logic          w16_out_valid;
  logic          w16_out_ready;
  logic [31:0]   w16_out_c;
  logic [7:0]    w16_out_tag;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [PW-1:0] c;
    logic [TW-1:0] tag;
  } exp_t;

  exp_t          exp_q[$];
  int            n_emit   = 0;
  logic          hold_chk = 1'b0;
  logic [PW-1:0] hold_c;
  logic [TW-1:0] hold_tag;

  int_mult_pipe #(.DATA_W(64), .CHUNK_W(16), .TAG_W(8)) u_dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_c(out_c), .out_tag(out_tag)
  );

  int_mult_pipe #(.DATA_W(40), .CHUNK_W(16), .TAG_W(8)) u_dut40 (
    .clk(clk), .reset(reset),
    .in_valid(w40_in_valid), .in_ready(w40_in_ready), .in_a(w40_a), .in_b(w40_b),
    .in_mode(w40_mode), .in_tag(w40_tag),
    .out_valid(w40_out_valid), .out_ready(w40_out_ready), .out_c(w40_out_c),
    .out_tag(w40_out_tag)
  );

  int_mult_pipe #(.DATA_W(16), .CHUNK_W(16), .TAG_W(8)) u_dut16 (
    .clk(clk), .reset(reset),
    .in_valid(w16_in_valid), .in_ready(w16_in_ready), .in_a(w16_a), .in_b(w16_b),
    .in_mode(w16_mode), .in_tag(w16_tag),
    .out_valid(w16_out_valid), .out_ready(w16_out_ready), .out_c(w16_out_c),
    .out_tag(w16_out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected run to finish");
    $fatal(1);
  end

  // Reference: exact product, then select the requested half
  function automatic logic [PW-1:0] model(input logic [DW-1:0] a,
                                          input logic [DW-1:0] b,
                                          input logic [1:0]    m);
    logic [PW-1:0] p;
    p = PW'(a) * PW'(b);
    case (m)
      2'b01:   return p % (PW'(1) << DW);
      2'b10:   return p >> DW;
      default: return p;
    endcase
  endfunction

  task automatic check(input string name, input logic [255:0] got,
                       input logic [255:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold current operand until accepted, bounded
  task automatic wait_accept();
    for (int g = 0; g < 200; g++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        return;
      end
      @(posedge clk);
      #1;
    end
    tests++;
    fails++;
    $display("FAIL accept_timeout: got in_ready low for 200 cycles, expected acceptance");
  endtask

  // Scoreboard and stall-hold checker for the 64-bit instance
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      hold_chk <= 1'b0;
    end else begin
      if (hold_chk)
        check("stall_hold", 256'({out_valid, out_tag, out_c}),
              256'({1'b1, hold_tag, hold_c}));
      hold_chk <= out_valid && !out_ready;
      hold_c   <= out_c;
      hold_tag <= out_tag;
      if (out_valid && out_ready) begin
        n_emit <= n_emit + 1;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_output: got tag 0x%0h result 0x%0h, expected no output",
                   out_tag, out_c);
        end else begin
          check("scoreboard", 256'({out_tag, out_c}), 256'({exp_q[0].tag, exp_q[0].c}));
          void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready)
        exp_q.push_back('{c: model(in_a, in_b, in_mode), tag: in_tag});
    end
  end

  initial begin
    logic saw_full;
    logic seen;
    int   emit_start;

    reset = 1'b1;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_mode = 2'b00; in_tag = '0; out_ready = 1'b1;
    w40_in_valid = 1'b0; w40_a = '0; w40_b = '0; w40_mode = 2'b00; w40_tag = 8'h40;
    w40_out_ready = 1'b1;
    w16_in_valid = 1'b0; w16_a = '0; w16_b = '0; w16_mode = 2'b00; w16_tag = 8'h16;
    w16_out_ready = 1'b1;

    // Reset state
    tick();
    tick();
    check("reset_out", 256'({out_valid, out_tag, out_c}), 256'(0));
    check("reset_small_valid", 256'({w40_out_valid, w16_out_valid}), 256'(0));
    reset = 1'b0;
    #1;
    check("reset_in_ready", 256'({in_ready, w40_in_ready, w16_in_ready}), 256'(3'b111));

    // All-ones square, partial top slice, single slice: exact 3-cycle latency
    tick();
    in_a = '1; in_b = '1; in_mode = MODE_FULL; in_tag = 8'h5A; in_valid = 1'b1;
    w40_a = 40'hFF_FFFF_FFFF; w40_b = 40'h2; w40_in_valid = 1'b1;
    w16_a = 16'h1234; w16_b = 16'h5678; w16_in_valid = 1'b1;
    tick();
    in_valid = 1'b0; w40_in_valid = 1'b0; w16_in_valid = 1'b0;
    tick();
    check("latency_early", 256'({out_valid, w40_out_valid, w16_out_valid}), 256'(0));
    tick();
    check("full_ones", 256'({out_valid, out_tag, out_c}),
          256'({1'b1, 8'h5A, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001}));
    check("w40_partial_slice", 256'({w40_out_valid, w40_out_tag, w40_out_c}),
          256'({1'b1, 8'h40, 80'h1FF_FFFF_FFFE}));
    check("w16_single_slice", 256'({w16_out_valid, w16_out_tag, w16_out_c}),
          256'({1'b1, 8'h16, 32'h0626_0060}));

    // Low then high half back-to-back
    in_a = '1; in_b = '1; in_mode = MODE_LO; in_tag = 8'h11; in_valid = 1'b1;
    tick();
    in_mode = MODE_HI; in_tag = 8'h22;
    tick();
    in_valid = 1'b0;
    tick();
    check("mode_lo", 256'({out_valid, out_tag, out_c}), 256'({1'b1, 8'h11, 128'h1}));
    tick();
    check("mode_hi", 256'({out_valid, out_tag, out_c}),
          256'({1'b1, 8'h22, 128'hFFFF_FFFF_FFFF_FFFE}));

    // Random stream with a consumer stall window
    tick();
    emit_start = n_emit;
    saw_full = 1'b0;
    fork
      begin : drv
        for (int k = 0; k < 10; k++) begin
          in_a = {$urandom(), $urandom()};
          in_b = {$urandom(), $urandom()};
          in_mode = 2'($urandom_range(0, 3));
          in_tag = 8'(8'h30 + k);
          in_valid = 1'b1;
          wait_accept();
        end
        in_valid = 1'b0;
      end
      begin : rdy
        for (int c = 0; c < 14; c++) begin
          out_ready = !(c >= 4 && c <= 8);
          @(negedge clk);
          if (!in_ready) saw_full = 1'b1;
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    for (int g = 0; g < 50 && exp_q.size() != 0; g++) tick();
    check("stream_drain", 256'(exp_q.size()), 256'(0));
    check("stream_count", 256'(n_emit - emit_start), 256'(10));
    check("stream_backpressure", 256'(saw_full), 256'(1));

    // Reset with three operations in flight
    in_a = 64'd7; in_b = 64'd9; in_mode = MODE_FULL; in_tag = 8'h41; in_valid = 1'b1;
    tick();
    in_tag = 8'h42;
    tick();
    in_tag = 8'h43;
    tick();
    in_valid = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    check("reset_flush_async", 256'({out_valid, out_tag, out_c}), 256'(0));
    tick();
    check("reset_flush_edge", 256'({out_valid, out_c}), 256'(0));
    reset = 1'b0;
    seen = 1'b0;
    for (int g = 0; g < 6; g++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    check("no_stale_after_reset", 256'(seen), 256'(0));
    check("in_ready_after_reset", 256'(in_ready), 256'(1));

    // Fresh operation after reset
    in_a = 64'd3; in_b = 64'd5; in_mode = MODE_FULL; in_tag = 8'h77; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("post_reset_early", 256'(out_valid), 256'(0));
    tick();
    check("post_reset_result", 256'({out_valid, out_tag, out_c}),
          256'({1'b1, 8'h77, 128'd15}));
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
